// File: rtl/pixel_stream_deframer.sv
// Pixel stream deframer: recovers (x, y) for every beat of a sop/eop framed
// colour stream, checks frame geometry and queues {x, y, colour} for a framebuffer.
module pixel_stream_deframer #(
    parameter int DATA_WIDTH    = 10,
    parameter int RBG_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RBG_SIZE-1:0]   i_in_colour,
    input  logic                  i_in_valid,
    input  logic                  i_in_sop,
    input  logic                  i_in_eop,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_out_x,
    output logic [DATA_WIDTH-1:0] o_out_y,
    output logic [RBG_SIZE-1:0]   o_out_colour,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_count,
    output logic [7:0]            o_err_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 2 * DATA_WIDTH + RBG_SIZE;
    localparam logic [DATA_WIDTH-1:0] LAST_X     = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] LAST_Y     = DATA_WIDTH'(SCREEN_HEIGHT - 1);
    localparam logic [AW:0]           FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        ACTIVE   = 2'd1,
        OVERRUN  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_x;
    logic [DATA_WIDTH-1:0]   r_y;
    logic                    r_stage_valid;
    logic [EW-1:0]           r_stage_data;
    logic                    r_frame_done;
    logic [15:0]             r_frame_count;
    logic [7:0]              r_err_count;

    logic [EW-1:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;

    logic [AW:0]             w_level;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_in_frame;
    logic                    w_take;
    logic [DATA_WIDTH-1:0]   w_px;
    logic [DATA_WIDTH-1:0]   w_py;
    logic [DATA_WIDTH-1:0]   w_nx;
    logic [DATA_WIDTH-1:0]   w_ny;
    logic                    w_last;
    logic                    w_restart;
    logic                    w_error;
    logic                    w_good;

    // The staging register counts toward occupancy so a full FIFO can never be overrun.
    assign w_level     = r_count + {{AW{1'b0}}, r_stage_valid};
    assign o_in_ready  = (w_level != FULL_LEVEL);
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = (r_count != '0);
    assign w_pop       = o_out_valid && i_out_ready;

    assign w_in_frame  = (r_state == ACTIVE);
    assign w_take      = w_accept && (w_in_frame || i_in_sop);
    assign w_px        = i_in_sop ? '0 : r_x;
    assign w_py        = i_in_sop ? '0 : r_y;
    assign w_last      = (w_px == LAST_X) && (w_py == LAST_Y);
    assign w_restart   = w_in_frame && i_in_sop;
    assign w_error     = w_restart || (i_in_eop != w_last);
    assign w_good      = i_in_eop && w_last && !w_restart;

    always_comb begin
        w_nx = w_px + DATA_WIDTH'(1);
        w_ny = w_py;
        if (w_px == LAST_X) begin
            w_nx = '0;
            w_ny = w_py + DATA_WIDTH'(1);
        end
    end

    // Frame tracking; OVERRUN only differs from WAIT_SOP in the state it reports.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= WAIT_SOP;
            r_x           <= '0;
            r_y           <= '0;
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_frame_done  <= 1'b0;
            r_stage_valid <= w_take;
            if (w_take) begin
                r_stage_data <= {w_px, w_py, i_in_colour};
                if (w_error && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
                if (w_good) begin
                    r_frame_done  <= 1'b1;
                    r_frame_count <= r_frame_count + 16'd1;
                end
                if (i_in_eop) begin
                    r_state <= WAIT_SOP;
                end else if (w_last) begin
                    r_state <= OVERRUN;
                end else begin
                    r_state <= ACTIVE;
                    r_x     <= w_nx;
                    r_y     <= w_ny;
                end
            end else if (w_accept && (r_state == OVERRUN) && i_in_eop) begin
                r_state <= WAIT_SOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (r_stage_valid) begin
                r_mem[r_wr_ptr] <= r_stage_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (r_stage_valid && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!r_stage_valid && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    assign {o_out_x, o_out_y, o_out_colour} = r_mem[r_rd_ptr];
    assign o_frame_done  = r_frame_done;
    assign o_frame_count = r_frame_count;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_pixel_stream_deframer.sv
// Randomised bench for pixel_stream_deframer on a reduced 16x4 screen; a pixel-index
// model predicts every output beat, ready/valid level and counter value.
module tb_pixel_stream_deframer;

    localparam int DW    = 10;
    localparam int CW    = 24;
    localparam int W     = 16;
    localparam int H     = 4;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] i_in_colour = '0;
    logic          i_in_valid = 1'b0;
    logic          i_in_sop = 1'b0;
    logic          i_in_eop = 1'b0;
    logic          o_in_ready;
    logic [DW-1:0] o_out_x;
    logic [DW-1:0] o_out_y;
    logic [CW-1:0] o_out_colour;
    logic          o_out_valid;
    logic          i_out_ready = 1'b0;
    logic          o_frame_done;
    logic [15:0]   o_frame_count;
    logic [7:0]    o_err_count;

    pixel_stream_deframer #(
        .DATA_WIDTH   (DW),
        .RBG_SIZE     (CW),
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_in_colour  (i_in_colour),
        .i_in_valid   (i_in_valid),
        .i_in_sop     (i_in_sop),
        .i_in_eop     (i_in_eop),
        .o_in_ready   (o_in_ready),
        .o_out_x      (o_out_x),
        .o_out_y      (o_out_y),
        .o_out_colour (o_out_colour),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_frame_done (o_frame_done),
        .o_frame_count(o_frame_count),
        .o_err_count  (o_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [CW-1:0] colour;
        int            visAt;
    } pix_t;

    pix_t        expQ[$];
    int          cyc = 0;
    bit          mInFrame = 0;
    int          mIdx = 0;
    logic [15:0] mFrames = '0;
    logic [7:0]  mErr = '0;
    logic        mDone = 1'b0;
    int          holdOff = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // A frame is just a running pixel index; position is index mod/div the width.
    task automatic modelBeat(input logic sop, input logic eop, input logic [CW-1:0] col);
        pix_t p;
        bit   restart;
        bit   lastPix;
        mDone = 1'b0;
        if (sop || mInFrame) begin
            restart = sop && mInFrame;
            if (sop) mIdx = 0;
            p.x      = DW'(mIdx % W);
            p.y      = DW'(mIdx / W);
            p.colour = col;
            p.visAt  = cyc + 1;
            expQ.push_back(p);
            lastPix = (mIdx == NPIX - 1);
            if ((restart || (eop != lastPix)) && (mErr != 8'hFF)) mErr = mErr + 8'd1;
            if (eop && lastPix && !restart) begin
                mFrames = mFrames + 16'd1;
                mDone   = 1'b1;
            end
            if (eop || lastPix) begin
                mInFrame = 0;
            end else begin
                mInFrame = 1;
                mIdx++;
            end
        end
    endtask

    task automatic stepCycle(output bit accepted);
        bit expReady;
        bit expValid;
        bit popNow;
        expReady = (expQ.size() < DEPTH);
        expValid = (expQ.size() > 0) && (expQ[0].visAt <= cyc);
        checkOutput("in_ready", 64'(o_in_ready), 64'(expReady));
        checkOutput("out_valid", 64'(o_out_valid), 64'(expValid));
        if (expValid) begin
            checkOutput("out_pixel", 64'({o_out_x, o_out_y, o_out_colour}),
                        64'({expQ[0].x, expQ[0].y, expQ[0].colour}));
        end
        popNow   = expValid && i_out_ready;
        accepted = i_in_valid && expReady;
        @(posedge clk);
        #1;
        cyc++;
        if (popNow) void'(expQ.pop_front());
        if (accepted) modelBeat(i_in_sop, i_in_eop, i_in_colour);
        else mDone = 1'b0;
        if (holdOff > 0) holdOff--;
        checkOutput("frame_done", 64'(o_frame_done), 64'(mDone));
        checkOutput("frame_count", 64'(o_frame_count), 64'(mFrames));
        checkOutput("err_count", 64'(o_err_count), 64'(mErr));
    endtask

    task automatic applyStimulus(input int nBeats, input bit firstSop, input int sop2, input int eopAt,
                                 input int validPct, input int readyPct);
        for (int i = 0; i < nBeats; i++) begin
            bit acc;
            int waitCnt;
            logic [CW-1:0] col;
            col     = CW'($urandom);
            acc     = 0;
            waitCnt = 0;
            while (!acc) begin
                i_in_colour = col;
                i_in_sop    = (firstSop && i == 0) || (i == sop2);
                i_in_eop    = (i == eopAt);
                i_in_valid  = ($urandom_range(99) < validPct);
                i_out_ready = (holdOff > 0) ? 1'b0 : ($urandom_range(99) < readyPct);
                stepCycle(acc);
                waitCnt++;
                if (!acc && waitCnt > 500) begin
                    checkOutput("accept_timeout", 64'(acc), 64'(1));
                    break;
                end
            end
        end
        i_in_valid = 1'b0;
        i_in_sop   = 1'b0;
        i_in_eop   = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        while (expQ.size() > 0 && n < 50) begin
            stepCycle(acc);
            n++;
        end
        if (expQ.size() != 0) begin
            miscompares++;
            $error("[TB] FAIL drain_timeout observed=%0d entries expected=0", expQ.size());
        end
        checkOutput("drained_valid", 64'(o_out_valid), 64'(0));
    endtask

    task automatic doReset();
        reset      = 1'b1;
        i_in_valid = 1'b0;
        i_in_sop   = 1'b0;
        i_in_eop   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        expQ.delete();
        mInFrame = 0;
        mIdx     = 0;
        mFrames  = '0;
        mErr     = '0;
        mDone    = 1'b0;
        holdOff  = 0;
        checkOutput("reset_out_valid", 64'(o_out_valid), 64'(0));
        checkOutput("reset_out_pixel", 64'({o_out_x, o_out_y, o_out_colour}), 64'(0));
        checkOutput("reset_frame_done", 64'(o_frame_done), 64'(0));
        checkOutput("reset_frame_count", 64'(o_frame_count), 64'(0));
        checkOutput("reset_err_count", 64'(o_err_count), 64'(0));
        reset = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(o_in_ready), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        doReset();

        $display("[TB] pre-sop garbage");
        applyStimulus(5, 1'b0, -1, -1, 100, 100);
        checkOutput("garbage_no_output", 64'(o_out_valid), 64'(0));

        $display("[TB] full frame");
        doReset();
        applyStimulus(NPIX, 1'b1, -1, NPIX - 1, 100, 100);
        drain();
        checkOutput("full_frame_count", 64'(o_frame_count), 64'(1));
        checkOutput("full_err_count", 64'(o_err_count), 64'(0));

        $display("[TB] backpressure");
        doReset();
        holdOff = 10;
        applyStimulus(NPIX, 1'b1, -1, NPIX - 1, 100, 100);
        drain();
        checkOutput("bp_frame_count", 64'(o_frame_count), 64'(1));

        $display("[TB] early eop then clean frame");
        doReset();
        applyStimulus(22, 1'b1, -1, 21, 100, 100);
        applyStimulus(NPIX, 1'b1, -1, NPIX - 1, 100, 100);
        drain();
        checkOutput("early_err_count", 64'(o_err_count), 64'(1));
        checkOutput("early_frame_count", 64'(o_frame_count), 64'(1));

        $display("[TB] missing eop then clean frame");
        doReset();
        applyStimulus(NPIX + 5, 1'b1, -1, NPIX + 4, 100, 100);
        applyStimulus(NPIX, 1'b1, -1, NPIX - 1, 100, 100);
        drain();
        checkOutput("overrun_err_count", 64'(o_err_count), 64'(1));
        checkOutput("overrun_frame_count", 64'(o_frame_count), 64'(1));

        $display("[TB] mid-frame sop");
        doReset();
        applyStimulus(NPIX + 20, 1'b1, 20, NPIX + 19, 100, 100);
        drain();
        checkOutput("midsop_err_count", 64'(o_err_count), 64'(1));
        checkOutput("midsop_frame_count", 64'(o_frame_count), 64'(1));

        $display("[TB] randomised frames");
        doReset();
        for (int f = 0; f < 12; f++) begin
            int kind;
            int vp;
            int rp;
            int k;
            kind = int'($urandom_range(3));
            vp   = int'($urandom_range(100, 50));
            rp   = int'($urandom_range(100, 30));
            k    = int'($urandom_range(NPIX - 2, 1));
            case (kind)
                0: applyStimulus(NPIX, 1'b1, -1, NPIX - 1, vp, rp);
                1: applyStimulus(k + 1, 1'b1, -1, k, vp, rp);
                2: applyStimulus(NPIX + 3, 1'b1, -1, NPIX + 2, vp, rp);
                default: applyStimulus(NPIX + k, 1'b1, k, NPIX + k - 1, vp, rp);
            endcase
        end
        drain();

        $display("[TB] reset mid-frame");
        applyStimulus(3, 1'b1, -1, -1, 100, 0);
        doReset();
        applyStimulus(NPIX, 1'b1, -1, NPIX - 1, 100, 100);
        drain();
        checkOutput("post_reset_frame_count", 64'(o_frame_count), 64'(1));

        $display("[TB] error counter saturation");
        doReset();
        for (int n = 0; n < 260; n++) begin
            applyStimulus(1, 1'b1, -1, 0, 100, 100);
        end
        drain();
        checkOutput("err_saturated", 64'(o_err_count), 64'(255));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
